// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and the
// range of operand widths the datapath is built for.
package serial_subtractor_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - c, with bo the borrow out.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ c;
    assign bo = (~a & b) | (~a & c) | (b & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through a single
// full-subtractor cell; d/bo are held from one done pulse to the next.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_chk
        $error("serial_subtractor: WIDTH out of supported range");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             brw_q, brw_d;
    logic             bo_q, bo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cell_d, cell_bo;
    logic             load;

    full_subtractor_bit u_cell (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .c  (brw_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    assign load = start && (state_q == ST_IDLE || state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        dout_d  = dout_q;
        brw_d   = brw_q;
        bo_d    = bo_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = {cell_d, res_q[WIDTH-1:1]};
                brw_d  = cell_bo;
                cnt_d  = cnt_q + CW'(1);
                // Last bit: the published result takes the fully shifted value.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    dout_d  = {cell_d, res_q[WIDTH-1:1]};
                    bo_d    = cell_bo;
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_IDLE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (load) begin
            a_sr_d  = a;
            b_sr_d  = b;
            brw_d   = bin;
            cnt_d   = '0;
            res_d   = '0;
            state_d = ST_SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            dout_q  <= '0;
            brw_q   <= 1'b0;
            bo_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            dout_q  <= dout_d;
            brw_q   <= brw_d;
            bo_q    <= bo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign d    = dout_q;
    assign bo   = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for the scenario
// tests and a 4-bit instance swept over every operand combination.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       start8, bin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bo8;
    logic [7:0] d8;

    logic       start4, bin4;
    logic [3:0] a4, b4;
    logic       busy4, done4, bo4;
    logic [3:0] d4;

    int tests;
    int fails;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .d     (d8),
        .bo    (bo8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .bin   (bin4),
        .busy  (busy4),
        .done  (done4),
        .d     (d4),
        .bo    (bo4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge: drives one 8-bit operation, follows it to its
    // done pulse and checks timing, held output, d and bo. Returns at the
    // falling edge where done is seen, with start already low.
    task automatic op8(input logic [7:0] a_i, input logic [7:0] b_i, input logic bin_i,
                       input logic [7:0] exp_d, input logic exp_bo,
                       input logic [7:0] prev_d, input string name);
        int  cyc;
        int  busy_cnt;
        bit  hold_ok;
        start8 = 1'b1;
        a8     = a_i;
        b8     = b_i;
        bin8   = bin_i;
        cyc = 0;
        busy_cnt = 0;
        hold_ok = 1'b1;
        do begin
            @(negedge clk);
            start8 = 1'b0;
            a8 = 8'hxx;
            b8 = 8'hxx;
            bin8 = 1'bx;
            cyc++;
            if (busy8 === 1'b1) begin
                busy_cnt++;
                if (d8 !== prev_d) hold_ok = 1'b0;
            end
        end while (done8 !== 1'b1 && cyc < 20);

        tests++;
        if (done8 !== 1'b1) begin
            fails++;
            $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
        end
        tests++;
        if (cyc !== 9) begin
            fails++;
            $display("FAIL %s latency: got %0d cycles, expected 9", name, cyc);
        end
        tests++;
        if (busy_cnt !== 8) begin
            fails++;
            $display("FAIL %s busy_cycles: got %0d, expected 8", name, busy_cnt);
        end
        tests++;
        if (!hold_ok) begin
            fails++;
            $display("FAIL %s d_hold: d changed while busy, expected %h", name, prev_d);
        end
        tests++;
        if (busy8 !== 1'b0) begin
            fails++;
            $display("FAIL %s busy_at_done: got %b, expected 0", name, busy8);
        end
        tests++;
        if (d8 !== exp_d) begin
            fails++;
            $display("FAIL %s d: got %h, expected %h", name, d8, exp_d);
        end
        tests++;
        if (bo8 !== exp_bo) begin
            fails++;
            $display("FAIL %s bo: got %b, expected %b", name, bo8, exp_bo);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy8, done8, d8, bo8} !== 11'd0) begin
            fails++;
            $display("FAIL reset_w8: busy=%b done=%b d=%h bo=%b, expected all 0",
                     busy8, done8, d8, bo8);
        end
        tests++;
        if ({busy4, done4, d4, bo4} !== 7'd0) begin
            fails++;
            $display("FAIL reset_w4: busy=%b done=%b d=%h bo=%b, expected all 0",
                     busy4, done4, d4, bo4);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b done=%b, expected 0 0", busy8, done8);
        end
    endtask

    task automatic test_basic();
        op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 8'h00, "basic_5a_3c");
        @(negedge clk);
        tests++;
        if (done8 !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse_width: done=%b one cycle after pulse, expected 0", done8);
        end
        tests++;
        if (d8 !== 8'h1E || bo8 !== 1'b0) begin
            fails++;
            $display("FAIL idle_hold: d=%h bo=%b, expected 1e 0", d8, bo8);
        end
    endtask

    task automatic test_borrow();
        op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 8'h1E, "borrow_0_minus_1");
        @(negedge clk);
        op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 8'hFF, "borrow_bin_only");
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        op8(8'h80, 8'h80, 1'b1, 8'hFF, 1'b1, 8'hFF, "b2b_first");
        // Second start is driven in the DONE cycle, so done-to-done is 9.
        op8(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 8'hFF, "b2b_second");
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int cyc;
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) begin
                start8 = 1'b1; a8 = 8'h33; b8 = 8'h00; bin8 = 1'b1;
            end else begin
                start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
            end
        end while (done8 !== 1'b1 && cyc < 20);
        tests++;
        if (done8 !== 1'b1 || cyc !== 9) begin
            fails++;
            $display("FAIL ignore_latency: done=%b after %0d cycles, expected 1 after 9", done8, cyc);
        end
        tests++;
        if (d8 !== 8'h0F || bo8 !== 1'b0) begin
            fails++;
            $display("FAIL ignore_result: d=%h bo=%b, expected 0f 0", d8, bo8);
        end
        @(negedge clk);
        tests++;
        if (busy8 !== 1'b0) begin
            fails++;
            $display("FAIL ignore_no_restart: busy=%b, expected 0", busy8);
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        start8 = 1'b1; a8 = 8'hC3; b8 = 8'h5A; bin8 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            start8 = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy8, done8, d8, bo8} !== 11'd0) begin
            fails++;
            $display("FAIL abort_async: busy=%b done=%b d=%h bo=%b, expected all 0",
                     busy8, done8, d8, bo8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) saw_done = 1'b1;
        end
        tests++;
        if (saw_done) begin
            fails++;
            $display("FAIL abort_no_done: activity seen after abort, expected none");
        end
        op8(8'h37, 8'h12, 1'b1, 8'h24, 1'b0, 8'h00, "after_abort");
        @(negedge clk);
    endtask

    task automatic test_sweep_w4();
        int cyc;
        int exp_i;
        logic [3:0] exp_d;
        logic       exp_bo;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    exp_i  = ai - bi - ci;
                    exp_d  = exp_i[3:0];
                    exp_bo = (ai < bi + ci);
                    start4 = 1'b1; a4 = 4'(ai); b4 = 4'(bi); bin4 = 1'(ci);
                    cyc = 0;
                    do begin
                        @(negedge clk);
                        start4 = 1'b0;
                        cyc++;
                    end while (done4 !== 1'b1 && cyc < 12);
                    tests++;
                    if (done4 !== 1'b1 || cyc !== 5) begin
                        fails++;
                        $display("FAIL w4_timing a=%h b=%h bin=%0d: done=%b after %0d cycles, expected 1 after 5",
                                 ai[3:0], bi[3:0], ci, done4, cyc);
                    end
                    tests++;
                    if (d4 !== exp_d || bo4 !== exp_bo) begin
                        fails++;
                        $display("FAIL w4_result a=%h b=%h bin=%0d: d=%h bo=%b, expected %h %b",
                                 ai[3:0], bi[3:0], ci, d4, bo4, exp_d, exp_bo);
                    end
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        test_sweep_w4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
